// File: rtl/rlbp_scan_seq.sv
// rtl/rlbp_scan_seq.sv - RLBP photodiode-pair scan sequencer with comparator capture
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   start, abort                 frame request (IDLE only) / return to IDLE
//   cont, mode                   continuous frames / 0 ring, 1 centre (latched at start)
//   t_rst, t_settle, t_sh, t_cmp phase durations in cycles (latched, 0 acts as 1)
//   cmp                          asynchronous comparator result from the analog macro
//   pd_a, pd_b                   one-hot photodiode pair selects
//   sh_rst, sh, sh_cmp           analog strobes
//   busy, ch_idx                 sequencer active / channel under conversion
//   code, code_valid, code_ready LBP code with valid/ready handshake
//   frame_cnt                    accepted frames, wrapping
module rlbp_scan_seq #(
    parameter int N_CH   = 12,
    parameter int CNT_W  = 8,
    parameter int CENTER = 0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cont,
    input  logic                    mode,
    input  logic [CNT_W-1:0]        t_rst,
    input  logic [CNT_W-1:0]        t_settle,
    input  logic [CNT_W-1:0]        t_sh,
    input  logic [CNT_W-1:0]        t_cmp,
    input  logic                    cmp,
    output logic [N_CH-1:0]         pd_a,
    output logic [N_CH-1:0]         pd_b,
    output logic                    sh_rst,
    output logic                    sh,
    output logic                    sh_cmp,
    output logic                    busy,
    output logic [$clog2(N_CH)-1:0] ch_idx,
    output logic [N_CH-1:0]         code,
    output logic                    code_valid,
    input  logic                    code_ready,
    output logic [15:0]             frame_cnt
);

    localparam int CH_W = $clog2(N_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SEL,
        S_SH,
        S_CMP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W:0]      cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
    logic [N_CH-1:0]     shadow_q, shadow_d;
    logic [N_CH-1:0]     code_q, code_d;
    logic                code_valid_q, code_valid_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                cont_q, cont_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    t_rst_q, t_rst_d;
    logic [CNT_W-1:0]    t_settle_q, t_settle_d;
    logic [CNT_W-1:0]    t_sh_q, t_sh_d;
    logic [CNT_W-1:0]    t_cmp_q, t_cmp_d;
    logic                cmp_meta_q, cmp_meta_d;
    logic                cmp_s_q, cmp_s_d;
    logic [CH_W-1:0]     ring_idx;
    logic                sel_on;

    // Durations are stored already clamped so a zero setting still gives one cycle.
    function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] t);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    // Phase counter counts down to zero; it is loaded with (duration - 1) on entry.
    function automatic logic [CNT_W:0] load(input logic [CNT_W-1:0] t);
        return {1'b0, t} - (CNT_W + 1)'(1);
    endfunction

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ch_idx_q     <= '0;
            shadow_q     <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
            cont_q       <= 1'b0;
            mode_q       <= 1'b0;
            t_rst_q      <= '0;
            t_settle_q   <= '0;
            t_sh_q       <= '0;
            t_cmp_q      <= '0;
            cmp_meta_q   <= 1'b0;
            cmp_s_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_idx_q     <= ch_idx_d;
            shadow_q     <= shadow_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            cont_q       <= cont_d;
            mode_q       <= mode_d;
            t_rst_q      <= t_rst_d;
            t_settle_q   <= t_settle_d;
            t_sh_q       <= t_sh_d;
            t_cmp_q      <= t_cmp_d;
            cmp_meta_q   <= cmp_meta_d;
            cmp_s_q      <= cmp_s_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_idx_d     = ch_idx_q;
        shadow_d     = shadow_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        frame_cnt_d  = frame_cnt_q;
        cont_d       = cont_q;
        mode_d       = mode_q;
        t_rst_d      = t_rst_q;
        t_settle_d   = t_settle_q;
        t_sh_d       = t_sh_q;
        t_cmp_d      = t_cmp_q;
        cmp_meta_d   = cmp;
        cmp_s_d      = cmp_meta_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    cont_d     = cont;
                    mode_d     = mode;
                    t_rst_d    = eff(t_rst);
                    t_settle_d = eff(t_settle);
                    t_sh_d     = eff(t_sh);
                    t_cmp_d    = eff(t_cmp);
                    ch_idx_d   = '0;
                    shadow_d   = '0;
                    cnt_d      = load(eff(t_rst));
                    state_d    = S_RST;
                end
            end
            S_RST: begin
                if (cnt_q == '0) begin
                    cnt_d   = load(t_settle_q);
                    state_d = S_SEL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SEL: begin
                if (cnt_q == '0) begin
                    cnt_d   = load(t_sh_q);
                    state_d = S_SH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SH: begin
                if (cnt_q == '0) begin
                    // Two extra compare cycles let the synchroniser catch up with cmp.
                    cnt_d   = {1'b0, t_cmp_q} + (CNT_W + 1)'(1);
                    state_d = S_CMP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CMP: begin
                if (cnt_q == '0) begin
                    shadow_d[ch_idx_q] = cmp_s_q;
                    if (ch_idx_q == LAST_CH) begin
                        code_d       = shadow_d;
                        code_valid_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        ch_idx_d = ch_idx_q + CH_W'(1);
                        cnt_d    = load(t_rst_q);
                        state_d  = S_RST;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (code_ready) begin
                    code_valid_d = 1'b0;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    ch_idx_d     = '0;
                    if (cont_q) begin
                        shadow_d = '0;
                        cnt_d    = load(t_rst_q);
                        state_d  = S_RST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything above, including a same-cycle handshake.
        if (abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            ch_idx_d     = '0;
            shadow_d     = '0;
            code_d       = code_q;
            code_valid_d = 1'b0;
            frame_cnt_d  = frame_cnt_q;
            cnt_d        = '0;
        end
    end

    assign ring_idx = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + CH_W'(1);
    assign sel_on   = (state_q == S_SEL) || (state_q == S_SH) || (state_q == S_CMP);

    // Strobes and selects decode straight from state so an async reset clears them at once.
    always_comb begin
        pd_a   = '0;
        pd_b   = '0;
        sh_rst = (state_q == S_RST);
        sh     = (state_q == S_SH);
        sh_cmp = (state_q == S_CMP);
        if (sel_on) begin
            pd_a = N_CH'(1) << ch_idx_q;
            pd_b = mode_q ? (N_CH'(1) << CENTER) : (N_CH'(1) << ring_idx);
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign ch_idx     = ch_idx_q;
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_rlbp_scan_seq.sv
// tb/tb_rlbp_scan_seq.sv - directed scoreboard bench for rlbp_scan_seq
module tb_rlbp_scan_seq;

    logic        clk;
    logic        rst_n;
    logic        start, abort, cont, mode;
    logic [7:0]  t_rst, t_settle, t_sh, t_cmp;
    logic        cmp;
    logic [11:0] pd_a, pd_b;
    logic        sh_rst, sh, sh_cmp, busy;
    logic [3:0]  ch_idx;
    logic [11:0] code;
    logic        code_valid, code_ready;
    logic [15:0] frame_cnt;

    logic [11:0] cmp_pat;
    logic [11:0] exp_q[$];
    int          exp_frames;
    int          tests;
    int          fails;
    logic [11:0] pd_a_ch11, pd_b_ch11;
    logic [11:0] last_code;

    rlbp_scan_seq #(.N_CH(12), .CNT_W(8), .CENTER(5)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .start      (start),
        .abort      (abort),
        .cont       (cont),
        .mode       (mode),
        .t_rst      (t_rst),
        .t_settle   (t_settle),
        .t_sh       (t_sh),
        .t_cmp      (t_cmp),
        .cmp        (cmp),
        .pd_a       (pd_a),
        .pd_b       (pd_b),
        .sh_rst     (sh_rst),
        .sh         (sh),
        .sh_cmp     (sh_cmp),
        .busy       (busy),
        .ch_idx     (ch_idx),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .frame_cnt  (frame_cnt)
    );

    // Comparator model: channel result follows the bench pattern for the channel being converted.
    assign cmp = cmp_pat[ch_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [11:0] pat, input bit push);
        cmp_pat = pat;
        if (push) exp_q.push_back(pat);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitors one frame from its first RST cycle until code_valid, then scores it.
    task automatic run_frame(input string tag, input int exp_lat, input int rst_len,
                             input bit centre, input bit poke);
        int          cyc;
        int          n_rst, n_sh, n_cmp, rst_hi;
        int          busy_bad, pd_bad;
        logic        p_rst, p_sh, p_cmp;
        logic [11:0] ea, eb;
        logic [11:0] e;
        cyc = 1; n_rst = 0; n_sh = 0; n_cmp = 0; rst_hi = 0;
        busy_bad = 0; pd_bad = 0;
        p_rst = 1'b0; p_sh = 1'b0; p_cmp = 1'b0;
        while (cyc <= 400 && !code_valid) begin
            if (!busy) busy_bad++;
            if (sh_rst && !p_rst) n_rst++;
            if (sh && !p_sh) n_sh++;
            if (sh_cmp && !p_cmp) n_cmp++;
            if (sh_rst) rst_hi++;
            p_rst = sh_rst; p_sh = sh; p_cmp = sh_cmp;
            if (sh_rst && (pd_a != 12'h000 || pd_b != 12'h000)) pd_bad++;
            if (sh || sh_cmp) begin
                ea = 12'h001 << ch_idx;
                if (centre) eb = 12'h020;
                else if (ch_idx == 4'd11) eb = 12'h001;
                else eb = 12'h001 << (ch_idx + 4'd1);
                if (pd_a != ea || pd_b != eb) pd_bad++;
                if (ch_idx == 4'd11 && sh) begin
                    pd_a_ch11 = pd_a;
                    pd_b_ch11 = pd_b;
                end
            end
            if (poke && cyc == 10) begin
                start = 1'b1; mode = ~centre; t_rst = 8'd7;
            end
            if (poke && cyc == 11) begin
                start = 1'b0; mode = centre; t_rst = 8'd1;
            end
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " busy"}, busy_bad, 0);
        check({tag, " pd"}, pd_bad, 0);
        check({tag, " sh_rst pulses"}, n_rst, 12);
        check({tag, " sh pulses"}, n_sh, 12);
        check({tag, " sh_cmp pulses"}, n_cmp, 12);
        check({tag, " sh_rst cycles"}, rst_hi, 12 * rst_len);
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, code_valid, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " code"}, code, e);
        end
        check({tag, " frame_cnt"}, frame_cnt, exp_frames);
        last_code = code;
    endtask

    task automatic accept(input string tag);
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
        exp_frames++;
        check({tag, " frame_cnt after accept"}, frame_cnt, exp_frames);
        check({tag, " code_valid after accept"}, code_valid, 0);
    endtask

    task automatic wait_phase(input string tag, input logic [3:0] ch, input bit on_sh);
        int n;
        n = 0;
        while (n < 300 && !(ch_idx == ch && (on_sh ? sh : sh_cmp))) begin
            tick();
            n++;
        end
        check({tag, " phase reached"}, (n < 300), 1);
    endtask

    initial begin
        int bad;
        logic [11:0] pat;
        tests = 0; fails = 0; exp_frames = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0; mode = 1'b0;
        t_rst = 8'd1; t_settle = 8'd1; t_sh = 8'd1; t_cmp = 8'd1;
        code_ready = 1'b0; cmp_pat = 12'h000;
        pd_a_ch11 = '0; pd_b_ch11 = '0; last_code = '0;
        tick(); tick();
        check("reset busy", busy, 0);
        check("reset strobes", {sh_rst, sh, sh_cmp}, 0);
        check("reset pd", {pd_a, pd_b}, 0);
        check("reset code", {code_valid, code}, 0);
        check("reset frame_cnt", frame_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // 1: ring, all durations 1, comparator high.
        start_frame(12'hFFF, 1'b1);
        check("t1 first cycle sh_rst", sh_rst, 1);
        run_frame("t1", 73, 1, 1'b0, 1'b0);
        accept("t1");
        check("t1 idle", busy, 0);

        // 2: ring, alternating results, ring wrap on channel 11.
        start_frame(12'h555, 1'b1);
        run_frame("t2", 73, 1, 1'b0, 1'b0);
        check("t2 ch11 pd_a", pd_a_ch11, 12'h800);
        check("t2 ch11 pd_b", pd_b_ch11, 12'h001);
        accept("t2");

        // 3: centre mode, mixed durations with t_cmp=0.
        mode = 1'b1; t_rst = 8'd2; t_settle = 8'd3; t_sh = 8'd1; t_cmp = 8'd0;
        start_frame(12'h3C9, 1'b1);
        mode = 1'b0; t_rst = 8'd1; t_settle = 8'd1; t_cmp = 8'd1;
        run_frame("t3", 109, 2, 1'b1, 1'b0);
        accept("t3");

        // 4: continuous mode with backpressure.
        cont = 1'b1;
        start_frame(12'hA0F, 1'b1);
        cont = 1'b0;
        run_frame("t4a", 73, 1, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (code !== 12'hA0F || code_valid !== 1'b1 || sh_rst || sh || sh_cmp) bad++;
        end
        check("t4 hold under backpressure", bad, 0);
        pat = 12'h1E3;
        cmp_pat = pat;
        exp_q.push_back(pat);
        accept("t4a");
        check("t4 restart sh_rst", sh_rst, 1);
        run_frame("t4b", 73, 1, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4 abort in done busy", busy, 0);
        check("t4 abort in done code_valid", code_valid, 0);
        check("t4 abort in done frame_cnt", frame_cnt, exp_frames);

        // 5: abort during channel 4 compare.
        start_frame(12'h0F0, 1'b0);
        wait_phase("t5", 4'd4, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5 busy", busy, 0);
        check("t5 strobes", {sh_rst, sh, sh_cmp}, 0);
        check("t5 pd", {pd_a, pd_b}, 0);
        check("t5 ch_idx", ch_idx, 0);
        check("t5 code_valid", code_valid, 0);
        check("t5 code kept", code, last_code);
        check("t5 frame_cnt", frame_cnt, exp_frames);
        start_frame(12'h6B2, 1'b1);
        run_frame("t5 after abort", 73, 1, 1'b0, 1'b0);
        accept("t5");

        // 6: async reset mid-frame, start while busy, abort+start in IDLE.
        start_frame(12'h00F, 1'b0);
        wait_phase("t6", 4'd7, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async busy", busy, 0);
        check("t6 async strobes", {sh_rst, sh, sh_cmp}, 0);
        check("t6 async pd", {pd_a, pd_b}, 0);
        check("t6 async code", {code_valid, code}, 0);
        check("t6 async ch_idx", ch_idx, 0);
        check("t6 async frame_cnt", frame_cnt, 0);
        exp_frames = 0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        start_frame(12'h9C6, 1'b1);
        run_frame("t6 start while busy", 73, 1, 1'b0, 1'b1);
        accept("t6");
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("t6 abort+start busy", busy, 0);
        check("t6 abort+start sh_rst", sh_rst, 0);
        tick();
        check("t6 still idle", busy, 0);
        check("t6 scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
